// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with start/busy/done handshake.
// Optional macro FAST_MUL_EN: MUL* ops use a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            MulDivOp,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic             special_q, special_d;
    logic [W-1:0]     mag_q, mag_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic             done_q, done_d;

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    endfunction

    // Operand preparation for the accepting edge
    logic         is_div_in, a_neg_in, b_neg_in, div_zero, div_ovf;
    logic [W-1:0] abs_a, abs_b, special_val;

    always_comb begin
        is_div_in   = MulDivOp[2];
        a_neg_in    = op_a_signed(MulDivOp) & SrcA[W-1];
        b_neg_in    = op_b_signed(MulDivOp) & SrcB[W-1];
        abs_a       = a_neg_in ? -SrcA : SrcA;
        abs_b       = b_neg_in ? -SrcB : SrcB;
        div_zero    = is_div_in && (SrcB == '0);
        div_ovf     = is_div_in && !MulDivOp[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        if (div_zero)
            special_val = MulDivOp[1] ? SrcA : '1;
        else
            special_val = MulDivOp[1] ? '0 : SrcA;
    end

    // One iteration: prod_q holds {acc, multiplier} for mul and {remainder, quotient} for div
    logic [W:0]     mul_sum, div_trial;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] step_val;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mag_q} : '0);
        div_trial = prod_q[2*W-1:W-1];
        div_ge    = div_trial >= {1'b0, mag_q};
        div_rem   = div_ge ? W'(div_trial - {1'b0, mag_q}) : div_trial[W-1:0];
        step_val  = op_q[2] ? {div_rem, prod_q[W-2:0], div_ge} : {mul_sum, prod_q[W-1:1]};
    end

    logic [2*W-1:0] mul_full;
    logic [W-1:0]   quo, rem, fin_val;
`ifdef FAST_MUL_EN
    logic [2*W-1:0] fa, fb;
`endif

    always_comb begin
`ifdef FAST_MUL_EN
        // Sign-extended operands; the low 2W bits of the product are exact
        fa       = {{W{op_a_signed(op_q) & prod_q[2*W-1]}}, prod_q[2*W-1:W]};
        fb       = {{W{op_b_signed(op_q) & prod_q[W-1]}}, prod_q[W-1:0]};
        mul_full = fa * fb;
`else
        mul_full = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
`endif
        quo = prod_q[W-1:0];
        rem = prod_q[2*W-1:W];
        if (special_q)
            fin_val = prod_q[W-1:0];
        else if (op_q[2])
            fin_val = op_q[1] ? (a_neg_q ? -rem : rem) : ((a_neg_q ^ b_neg_q) ? -quo : quo);
        else
            fin_val = (op_q[1:0] == 2'b00) ? mul_full[W-1:0] : mul_full[2*W-1:W];
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        special_d = special_q;
        mag_d     = mag_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d      = MulDivOp;
                        a_neg_d   = a_neg_in;
                        b_neg_d   = b_neg_in;
                        cnt_d     = '0;
                        special_d = div_zero || div_ovf;
                        if (div_zero || div_ovf) begin
                            prod_d  = {{W{1'b0}}, special_val};
                            state_d = FIN;
`ifdef FAST_MUL_EN
                        end else if (!is_div_in) begin
                            prod_d  = {SrcA, SrcB};
                            state_d = FIN;
`endif
                        end else begin
                            mag_d   = is_div_in ? abs_b : abs_a;
                            prod_d  = {{W{1'b0}}, (is_div_in ? abs_a : abs_b)};
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    prod_d = step_val;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1))
                        state_d = FIN;
                end
                FIN: begin
                    result_d = fin_val;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            mag_q     <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            special_q <= special_d;
            mag_q     <= mag_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign Busy   = (state_q != IDLE);
    assign Done   = done_q;
    assign Result = result_q;
    assign Zero   = (result_q == '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised bench for muldiv_unit with a result scoreboard queue.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   MulDivOp = '0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         Busy, Done, Zero;
    logic [W-1:0] Result;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] last_result = '0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .MulDivOp(MulDivOp),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result), .Zero(Zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for Done, check latency, result, Busy and pulse width.
    // poke>0 pulses start (with other operands) after that many edges while busy.
    task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                       input int poke);
        logic [W-1:0] want;
        int  k;
        bit  got;
        bit  busy_ok;
        @(negedge clk);
        start = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
        sb.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; SrcA = $urandom; SrcB = $urandom; MulDivOp = 3'($urandom);
        busy_ok = Busy;
        got = 1'b0;
        k = 0;
        while (!got && k < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (Done) got = 1'b1;
            else begin
                if (!Busy) busy_ok = 1'b0;
                if (k == poke) start = 1'b1;
            end
        end
        start = 1'b0;
        want = sb.pop_front();
        chk({tag, "_done_seen"}, W'(got), W'(1));
        chk({tag, "_latency"}, W'(k), W'(lat));
        chk({tag, "_result"}, Result, want);
        chk({tag, "_busy_held"}, W'(busy_ok), W'(1));
        $display("txn %s op=%0d a=0x%h b=0x%h result=0x%h edges=%0d", tag, op, a, b, Result, k);
        last_result = Result;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, W'(Done), W'(0));
    endtask

    initial begin
        logic [W-1:0] ra, rb, prior;
        logic [2*W-1:0] wide;
        int nd;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", W'(Busy), W'(0));
        chk("rst_done", W'(Done), W'(0));
        chk("rst_result", Result, '0);
        chk("rst_zero", W'(Zero), W'(1));
        @(negedge clk) rst = 1'b0;

        run("mul_7_m3",  3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 0);
        run("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
        run("mulhu_min", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
        run("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 0);
        run("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT, 0);
        run("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT, 0);
        run("divu_2",    3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, DIV_LAT, 0);
        run("remu_2",    3'b111, 32'hFFFFFFF9, 32'd2, 32'd1, DIV_LAT, 0);
        run("divu_by0",  3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        run("rem_by0",   3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
        run("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);
        chk("rem_ovf_zero", W'(Zero), W'(1));

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            wide = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run("rnd_mulhu", 3'b011, ra, rb, wide[2*W-1:W], MUL_LAT, 0);
            run("rnd_mul", 3'b000, ra, rb, wide[W-1:0], MUL_LAT, 0);
            rb = W'($urandom_range(1, 5000));
            if (i == 1) rb = -rb;
            run("rnd_div", 3'b100, ra, rb, W'($signed(ra) / $signed(rb)), DIV_LAT, 0);
            run("rnd_rem", 3'b110, ra, rb, W'($signed(ra) % $signed(rb)), DIV_LAT, 0);
            run("rnd_divu", 3'b101, ra, rb, ra / rb, DIV_LAT, 0);
        end

        // Start pulses while busy (mid-CALC and in FIN) must be ignored
        run("divu_poke_calc", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT, 5);
        run("divu_poke_fin",  3'b111, 32'd100, 32'd7, 32'd2, DIV_LAT, DIV_LAT - 1);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Done) nd++;
        end
        chk("poke_no_second_done", W'(nd), W'(0));
        chk("poke_idle", W'(Busy), W'(0));

        // Flush mid-CALC: no Done, Result unchanged
        prior = last_result;
        @(negedge clk);
        start = 1'b1; MulDivOp = 3'b100; SrcA = -32'd100; SrcB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", W'(Busy), W'(0));
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Done) nd++;
        end
        chk("flush_no_done", W'(nd), W'(0));
        chk("flush_result_kept", Result, prior);
        $display("txn flush_div result=0x%h dones=%0d", Result, nd);

        // Flush together with start drops the start
        @(negedge clk);
        start = 1'b1; flush = 1'b1; MulDivOp = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_drop", W'(Busy), W'(0));

        // Async reset mid-CALC
        run("pre_rst_mul", 3'b000, 32'd5, 32'd3, 32'd15, MUL_LAT, 0);
        @(negedge clk);
        start = 1'b1; MulDivOp = 3'b100; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", W'(Busy), W'(0));
        chk("arst_done", W'(Done), W'(0));
        chk("arst_result", Result, '0);
        $display("txn async_reset busy=%0b done=%0b result=0x%h", Busy, Done, Result);
        @(negedge clk) rst = 1'b0;
        run("post_rst_mul", 3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT, 0);
        run("post_rst_div", 3'b100, 32'd1000, 32'hFFFFFFFD, -32'd333, DIV_LAT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
